// File: rtl/score_scan_mux_pkg.sv
// Shared types and constants for the score display path (FSM states, clamp limit, conversion length).
// Latency: none (declarations only).
// Backpressure: not applicable.
package score_scan_mux_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    localparam int SCORE_W     = 14;
    localparam int BCD_W       = 16;
    localparam int SCORE_MAX   = 9999;
    localparam int CONV_CYCLES = 14;
    localparam int CNT_W       = 4;

    function automatic logic [SCORE_W-1:0] clamp_score(input logic [SCORE_W-1:0] s);
        return (s > SCORE_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : s;
    endfunction

endpackage

// File: rtl/score_scan_mux_bin2bcd_seq.sv
// Sequential double-dabble converter: 14-bit binary to four packed BCD digits.
// Latency: start edge loads, then 14 shift-add-3 edges; done is high during the cycle before the last edge.
// Backpressure: none; a new start restarts the conversion unconditionally.
module bin2bcd_seq
    import score_scan_mux_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [SCORE_W-1:0] bin,
    output logic               busy,
    output logic               done,
    output logic [BCD_W-1:0]   bcd
);

    logic [SCORE_W-1:0] bin_sr;
    logic [BCD_W-1:0]   bcd_sr;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CNT_W-1:0]   cnt;
    logic               run;

    // Add 3 to any digit >= 5 so the following left shift carries correctly into the next digit.
    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < 4; i++) begin
            if (bcd_adj[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_sr <= '0;
            bcd_sr <= '0;
            cnt    <= '0;
            run    <= 1'b0;
        end else if (start) begin
            bin_sr <= bin;
            bcd_sr <= '0;
            cnt    <= '0;
            run    <= 1'b1;
        end else if (run) begin
            bcd_sr <= {bcd_adj[BCD_W-2:0], bin_sr[SCORE_W-1]};
            bin_sr <= {bin_sr[SCORE_W-2:0], 1'b0};
            cnt    <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(CONV_CYCLES - 1)) begin
                run <= 1'b0;
            end
        end
    end

    assign busy = run;
    assign done = run && (cnt == CNT_W'(CONV_CYCLES - 1));
    assign bcd  = bcd_sr;

endmodule

// File: rtl/score_scan_mux.sv
// Score to 4-digit multiplexed 7-seg driver; optional leading-zero blanking under LEADING_ZERO_BLANK_EN.
// Latency: strobe at edge N -> display register updated at edge N+15; scan outputs registered one cycle.
// Backpressure: none; strobes while busy are held in a one-deep pending slot, last value wins.
module score_scan_mux
    import score_scan_mux_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SCORE_W-1:0] score,
    input  logic               score_vld,
    output logic               busy,
    output logic [3:0]         digit_nib,
    output logic [3:0]         digit_sel
);

    localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    state_t             state, state_nxt;
    logic               pend;
    logic [SCORE_W-1:0] pend_val;
    logic [BCD_W-1:0]   disp;
    logic               conv_start;
    logic [SCORE_W-1:0] conv_val;
    logic               conv_busy;
    logic               conv_done;
    logic [BCD_W-1:0]   conv_bcd;

    logic [DIV_W-1:0]   div;
    logic [1:0]         idx;
    logic [3:0]         sel_nxt;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (conv_val),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // A strobe arriving in LOAD is newer than any pending value, so it is started directly.
    always_comb begin
        state_nxt  = state;
        conv_start = 1'b0;
        conv_val   = clamp_score(score);
        case (state)
            IDLE: begin
                if (score_vld) begin
                    conv_start = 1'b1;
                    state_nxt  = CONV;
                end
            end
            CONV: begin
                if (conv_done) begin
                    state_nxt = LOAD;
                end else if (!conv_busy) begin
                    state_nxt = IDLE;
                end
            end
            LOAD: begin
                if (pend || score_vld) begin
                    conv_start = 1'b1;
                    state_nxt  = CONV;
                    if (!score_vld) begin
                        conv_val = pend_val;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pend     <= 1'b0;
            pend_val <= '0;
            disp     <= '0;
        end else begin
            state <= state_nxt;
            if (state == LOAD) begin
                disp <= conv_bcd;
                pend <= 1'b0;
            end else if (score_vld && (state != IDLE)) begin
                pend     <= 1'b1;
                pend_val <= clamp_score(score);
            end
        end
    end

    assign busy = (state != IDLE);

`ifdef LEADING_ZERO_BLANK_EN
    logic [1:0] msd;

    always_comb begin
        msd = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (disp[4*i +: 4] != 4'd0) begin
                msd = 2'(i);
            end
        end
        sel_nxt = (idx > msd) ? 4'b1111 : ~(4'b0001 << idx);
    end
`else
    always_comb begin
        sel_nxt = ~(4'b0001 << idx);
    end
`endif

    // Scanner is free-running and never waits on the conversion FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            div       <= '0;
            idx       <= 2'd0;
            digit_sel <= 4'b1110;
            digit_nib <= 4'h0;
        end else begin
            if (div == DIV_W'(REFRESH_DIV - 1)) begin
                div <= '0;
                idx <= idx + 2'd1;
            end else begin
                div <= div + DIV_W'(1);
            end
            digit_sel <= sel_nxt;
            digit_nib <= disp[{idx, 2'b00} +: 4];
        end
    end

endmodule

// File: tb/tb_score_scan_mux.sv
// Self-checking bench for score_scan_mux with REFRESH_DIV = 4; a cycle-level score/display model
// is checked every cycle, and directed scenarios pin digit values and busy lengths with literals.
module tb_score_scan_mux;

    localparam int RD = 4;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] score;
    logic        score_vld;
    logic        busy;
    logic [3:0]  digit_nib;
    logic [3:0]  digit_sel;

    int checks = 0;
    int errors = 0;

    score_scan_mux #(.REFRESH_DIV(RD)) dut (
        .clk       (clk),
        .rst       (rst),
        .score     (score),
        .score_vld (score_vld),
        .busy      (busy),
        .digit_nib (digit_nib),
        .digit_sel (digit_sel)
    );

    always #5 clk = ~clk;

    // Model: a conversion occupies 15 edges; display value changes on the 15th edge after its start.
    bit   started = 1'b0;
    int   e = 0;
    bit   m_active = 1'b0;
    bit   m_pend = 1'b0;
    int   m_pend_val = 0;
    int   m_cur = 0;
    int   m_load = 0;
    int   m_disp = 0;
    int   m_slot = 0;
    logic [3:0] exp_sel = 4'b1110;
    logic [3:0] exp_nib = 4'h0;

    function automatic int clampv(input int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    function automatic int pow10(input int s);
        int p = 1;
        for (int k = 0; k < s; k++) p = p * 10;
        return p;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            started  = 1'b1;
            e        = 0;
            m_active = 1'b0;
            m_pend   = 1'b0;
            m_disp   = 0;
            m_slot   = 0;
            exp_sel  = 4'b1110;
            exp_nib  = 4'h0;
        end else if (started) begin
            m_slot  = (e / RD) % 4;
            exp_nib = 4'((m_disp / pow10(m_slot)) % 10);
            if (BLANK && m_slot > 0 && m_disp < pow10(m_slot))
                exp_sel = 4'b1111;
            else
                exp_sel = ~(4'b0001 << m_slot);
            e++;
            if (m_active && e == m_load) begin
                m_disp = m_cur;
                if (score_vld || m_pend) begin
                    m_cur  = score_vld ? clampv(int'(score)) : m_pend_val;
                    m_pend = 1'b0;
                    m_load = e + 15;
                end else begin
                    m_active = 1'b0;
                end
            end else if (score_vld) begin
                if (m_active) begin
                    m_pend     = 1'b1;
                    m_pend_val = clampv(int'(score));
                end else begin
                    m_active = 1'b1;
                    m_cur    = clampv(int'(score));
                    m_load   = e + 15;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            checks++;
            if (busy !== m_active) begin
                errors++;
                $display("FAIL model_busy t=%0t: got %b expected %b", $time, busy, m_active);
            end
            checks++;
            if (digit_sel !== exp_sel) begin
                errors++;
                $display("FAIL model_sel t=%0t: got %b expected %b", $time, digit_sel, exp_sel);
            end
            checks++;
            if (digit_nib !== exp_nib) begin
                errors++;
                $display("FAIL model_nib t=%0t: got %h expected %h", $time, digit_nib, exp_nib);
            end
        end
    end

    task automatic check_val(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Walk slots 0..3 and compare against hand-computed digits; nd = digits shown when blanking.
    task automatic show(input string name, input int d0, input int d1, input int d2, input int d3,
                        input int nd);
        int d [4];
        int t;
        int want_sel;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        for (int s = 0; s < 4; s++) begin
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (m_slot != s && t < 40);
            if (t >= 40) begin
                check_val({name, "_slot_timeout"}, t, 0);
            end else begin
                want_sel = (BLANK && s >= nd) ? 4'b1111 : int'(4'(~(4'b0001 << s)));
                check_val($sformatf("%s_nib%0d", name, s), int'(digit_nib), d[s]);
                check_val($sformatf("%s_sel%0d", name, s), int'(digit_sel), want_sel);
            end
        end
    endtask

    task automatic strobe(input int v);
        @(negedge clk);
        score     = 14'(v);
        score_vld = 1'b1;
        @(negedge clk);
        score_vld = 1'b0;
    endtask

    task automatic busy_len(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        score     = '0;
        score_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_sel", int'(digit_sel), 14);
        check_val("reset_nib", int'(digit_nib), 0);
        check_val("reset_busy", int'(busy), 0);
        rst = 1'b0;
        repeat (32) @(negedge clk);
        show("idle", 0, 0, 0, 0, 1);

        strobe(1234);
        busy_len(n);
        check_val("busy_1234", n, 15);
        @(negedge clk);
        show("s1234", 4, 3, 2, 1, 4);

        strobe(12000);
        busy_len(n);
        check_val("busy_clamp", n, 15);
        @(negedge clk);
        show("s12000", 9, 9, 9, 9, 4);

        strobe(5);
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (n == 3) begin score = 14'd77;  score_vld = 1'b1; end
            if (n == 4) score_vld = 1'b0;
            if (n == 6) begin score = 14'd300; score_vld = 1'b1; end
            if (n == 7) score_vld = 1'b0;
            @(negedge clk);
        end
        check_val("busy_chain", n, 30);
        @(negedge clk);
        show("s300", 0, 0, 3, 0, 3);

        strobe(4321);
        repeat (6) @(negedge clk);
        rst       = 1'b1;
        score     = 14'd999;
        score_vld = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        score_vld = 1'b0;
        check_val("abort_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        check_val("abort_busy_late", int'(busy), 0);
        show("abort", 0, 0, 0, 0, 1);

        strobe(42);
        busy_len(n);
        check_val("busy_42", n, 15);
        @(negedge clk);
        show("s42", 2, 4, 0, 0, 2);

        strobe(0);
        busy_len(n);
        check_val("busy_0", n, 15);
        @(negedge clk);
        show("s0", 0, 0, 0, 0, 1);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/score_scan_mux.md
SCORE_SCAN_MUX -- requirements
Module: score_scan_mux

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 50000, giving clock cycles per digit slot (legal values 2 or more).
REQ-002 The block SHALL have port clk, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, the reset; reset is synchronous and active-high.
REQ-004 The block SHALL have port score, input, 14 bits, the unsigned binary score to display.
REQ-005 The block SHALL have port score_vld, input, 1 bit, a one-cycle strobe that samples score.
REQ-006 The block SHALL have port busy, output, 1 bit, high while a binary-to-BCD conversion is in progress.
REQ-007 The block SHALL have port digit_nib, output, 4 bits, the BCD digit for the active slot; it feeds the seg7 decoder input.
REQ-008 The block SHALL have port digit_sel, output, 4 bits, the active-low digit enable; bit 0 is the rightmost (ones) digit.

Function
REQ-009 The block SHALL clamp a sampled score above 9999 to 9999 before conversion.
REQ-010 The conversion FSM SHALL have states IDLE, CONV and LOAD; reset enters IDLE.
REQ-011 IDLE -> CONV SHALL occur on score_vld; the clamped score is captured on that edge.
REQ-012 CONV SHALL run exactly 14 shift-add-3 (double-dabble) cycles, then move to LOAD.
REQ-013 LOAD SHALL copy the 16-bit BCD result into the display register in one cycle, then return to IDLE.
REQ-014 With score_vld sampled at edge N, busy SHALL be high for the cycles following edges N through N+14, and the new display value SHALL take effect at edge N+15.
REQ-015 score_vld while busy SHALL set a pending flag and overwrite a pending value; the last value wins.
REQ-016 If a value is pending at LOAD, the FSM SHALL go to CONV with that value instead of IDLE, and clear the pending flag.
REQ-017 The display register SHALL change only in LOAD; the displayed digits never show a partially converted value.
REQ-018 The scan divider SHALL count 0..REFRESH_DIV-1 and wrap; the slot index SHALL advance 0->1->2->3->0 on each wrap.
REQ-019 The scanner SHALL run every cycle independently of the FSM.
REQ-020 digit_sel SHALL be ~(1 << index), and digit_nib SHALL be the display nibble for that index; both are registered and update together.

Reset
REQ-021 On rst, the following SHALL reset: FSM to IDLE, display register to 0000, pending cleared, divider 0, index 0, busy 0, digit_sel 4'b1110, digit_nib 4'h0.
REQ-022 rst during CONV or LOAD SHALL abort the conversion; the display register SHALL read 0000 afterwards.
REQ-023 score_vld in the same cycle as rst SHALL be ignored.

Configuration
REQ-024 Macro LEADING_ZERO_BLANK_EN SHALL control leading-zero blanking.
REQ-025 When LEADING_ZERO_BLANK_EN is defined, any digit above the most significant nonzero digit SHALL drive digit_sel 4'b1111 for its slot; the ones digit is never blanked, so 0 shows as a single 0.
REQ-026 When LEADING_ZERO_BLANK_EN is not defined, all four digits SHALL always be enabled, including leading zeros.

Structure
REQ-027 A shared package SHALL hold the FSM state enum (IDLE/CONV/LOAD), the SCORE_MAX = 9999 constant and the CONV_CYCLES = 14 constant.
REQ-028 The binary-to-BCD converter SHALL be one sub-module, bin2bcd_seq (start, busy, done, 16-bit BCD out); the scanner stays in the top module.

Verification (bench uses REFRESH_DIV = 4)
REQ-029 Reset, then idle 32 cycles -> digit_sel cycles 1110,1101,1011,0111 every 4 cycles, and digit_nib = 0 in every slot.
REQ-030 score = 1234 with score_vld at edge N -> busy high for 15 cycles; from edge N+15, slots 0..3 show 4,3,2,1.
REQ-031 score = 12000 -> slots show 9,9,9,9.
REQ-032 score = 5, then 77 strobed during busy, then 300 strobed during busy -> 5 is displayed, then 300 (0,0,3,0 in slots 0..3); 77 never appears; busy stays high across the back-to-back conversion.
REQ-033 rst asserted 7 cycles into converting 4321 -> busy = 0 and display 0000 after reset; a following strobe of 42 shows 2,4,0,0.
REQ-034 With LEADING_ZERO_BLANK_EN defined, score = 42 -> slots 2 and 3 drive digit_sel 1111; score = 0 -> only slot 0 is enabled, showing 0.
